my_scan_mux: RTL and testbench

Parametrised, registered N-channel, W-bit selector: the clocked successor of the processor's 16-way combinational mux. It adds three modes: direct select, masked round-robin auto-scan with a programmable dwell time, and hold. It also reports the active channel and a wrap pulse. It sits between the register/display data buses and consumers that need either one channel on demand or a time-multiplexed sweep, for example seven-segment digit scanning.

---
 rtl/my_scan_mux.sv | 82 ++++++++
 tb/tb_my_scan_mux.sv | 129 ++++++++++++
 2 files changed

// File: rtl/my_scan_mux.sv
// my_scan_mux: registered N-channel selector with direct, masked round-robin scan and hold modes.
module my_scan_mux #(
  parameter int W  = 4,
  parameter int N  = 16,
  parameter int SW = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  din,
  input  logic [SW-1:0]   select,
  input  logic [1:0]      mode,
  input  logic [DW-1:0]   dwell,
  input  logic [N-1:0]    mask,
  output logic [W-1:0]    o1,
  output logic [SW-1:0]   ch,
  output logic            valid,
  output logic            wrap
);
  logic [DW-1:0] dwell_cnt;
  logic [SW-1:0] above, lowest, nch;
  logic [W-1:0]  dir_data, scan_data;
  logic          found, cur_en, sel_ok, adv;
  // Matching indices by equality keeps lookups in range when 2^SW > N.
  always_comb begin
    above = '0;
    lowest = '0;
    found = 1'b0;
    cur_en = 1'b0;
    sel_ok = 1'b0;
    dir_data = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[k]) begin
        lowest = SW'(k);
        if (k > int'(ch)) begin
          above = SW'(k);
          found = 1'b1;
        end
        if (SW'(k) == ch) cur_en = 1'b1;
      end
      if (SW'(k) == select) begin
        sel_ok = 1'b1;
        dir_data = din[k*W +: W];
      end
    end
  end
  assign adv = !cur_en || dwell_cnt >= dwell;
  assign nch = adv ? (found ? above : lowest) : ch;
  always_comb begin
    scan_data = '0;
    for (int k = 0; k < N; k++)
      if (SW'(k) == nch) scan_data = din[k*W +: W];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o1 <= '0;
      ch <= '0;
      valid <= 1'b0;
      wrap <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      wrap <= 1'b0;
      if (mode == 2'b00) begin
        dwell_cnt <= '0;
        valid <= sel_ok;
        o1 <= sel_ok ? dir_data : '0;
        if (sel_ok) ch <= select;
      end else if (mode == 2'b01) begin
        if (mask == '0) begin
          o1 <= '0;
          valid <= 1'b0;
        end else begin
          ch <= nch;
          o1 <= scan_data;
          valid <= 1'b1;
          wrap <= adv && !found;
          dwell_cnt <= adv ? '0 : dwell_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_my_scan_mux.sv
// tb_my_scan_mux: directed scoreboard bench for my_scan_mux (N=16 main instance, N=12 for illegal select).
module tb_my_scan_mux;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] din;
  logic [3:0]  select, select12;
  logic [1:0]  mode, mode12;
  logic [7:0]  dwell, dwell12;
  logic [15:0] mask;
  logic [11:0] mask12;
  logic [3:0]  o1, ch, o1_12, ch_12;
  logic        valid, wrap, valid_12, wrap_12;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    string      tag;
    bit         which;
    logic [9:0] exp;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  my_scan_mux #(.W(4), .N(16), .SW(4), .DW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .select(select), .mode(mode),
    .dwell(dwell), .mask(mask), .o1(o1), .ch(ch), .valid(valid), .wrap(wrap)
  );

  my_scan_mux #(.W(4), .N(12), .SW(4), .DW(8)) u_d12 (
    .clk(clk), .rst_n(rst_n), .din(din[47:0]), .select(select12), .mode(mode12),
    .dwell(dwell12), .mask(mask12), .o1(o1_12), .ch(ch_12), .valid(valid_12), .wrap(wrap_12)
  );

  task automatic compare(input exp_t e);
    logic [9:0] obs;
    obs = e.which ? {o1_12, ch_12, valid_12, wrap_12} : {o1, ch, valid, wrap};
    vectors++;
    assert (obs === e.exp) else begin
      miscompares++;
      $error("FAIL %s observed o1/ch/valid/wrap=%h/%h/%b/%b expected=%h/%h/%b/%b",
             e.tag, obs[9:6], obs[5:2], obs[1], obs[0],
             e.exp[9:6], e.exp[5:2], e.exp[1], e.exp[0]);
    end
  endtask

  task automatic step(input string tag, input bit which, input logic [3:0] eo, input logic [3:0] ec,
                      input logic ev, input logic ew);
    q.push_back('{tag, which, {eo, ec, ev, ew}});
    @(posedge clk);
    #1;
    while (q.size() > 0) compare(q.pop_front());
  endtask

  task automatic set_din(input bit rev);
    for (int k = 0; k < 16; k++) din[k*4 +: 4] = rev ? 4'(15 - k) : 4'(k);
  endtask

  initial begin
    int seq[12] = '{0, 0, 3, 3, 3, 7, 7, 7, 0, 0, 0, 3};
    rst_n = 1'b0;
    set_din(1'b0);
    select = 4'd0; mode = 2'b00; dwell = 8'd0; mask = 16'h0;
    select12 = 4'd0; mode12 = 2'b10; dwell12 = 8'd0; mask12 = 12'h0;
    #1;
    compare('{"reset", 1'b0, 10'h0});
    @(negedge clk);
    rst_n = 1'b1;
    select = 4'd5;
    step("direct_5", 1'b0, 4'd5, 4'd5, 1'b1, 1'b0);
    select = 4'd9;
    step("direct_9", 1'b0, 4'd9, 4'd9, 1'b1, 1'b0);
    set_din(1'b1);
    step("direct_9_rev", 1'b0, 4'd6, 4'd9, 1'b1, 1'b0);
    set_din(1'b0);
    mode12 = 2'b00; select12 = 4'd3;
    step("n12_sel3", 1'b1, 4'd3, 4'd3, 1'b1, 1'b0);
    select12 = 4'd13;
    step("n12_sel13", 1'b1, 4'd0, 4'd3, 1'b0, 1'b0);
    select12 = 4'd3;
    step("n12_sel3_again", 1'b1, 4'd3, 4'd3, 1'b1, 1'b0);
    mode12 = 2'b01; mask12 = 12'h800;
    step("n12_scan_top", 1'b1, 4'd11, 4'd11, 1'b1, 1'b0);
    step("n12_scan_wrap_self", 1'b1, 4'd11, 4'd11, 1'b1, 1'b1);
    mode12 = 2'b10;
    select = 4'd0;
    step("direct_0", 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    mode = 2'b01; mask = 16'h0089; dwell = 8'd2;
    for (int i = 0; i < 12; i++)
      step($sformatf("scan89_%0d", i), 1'b0, 4'(seq[i]), 4'(seq[i]), 1'b1, i == 8);
    mode = 2'b00; select = 4'd5;
    step("direct_5b", 1'b0, 4'd5, 4'd5, 1'b1, 1'b0);
    mode = 2'b01; mask = 16'h0100;
    step("scan_entry", 1'b0, 4'd8, 4'd8, 1'b1, 1'b0);
    step("scan_cnt1", 1'b0, 4'd8, 4'd8, 1'b1, 1'b0);
    set_din(1'b1);
    mode = 2'b10;
    step("hold_0", 1'b0, 4'd8, 4'd8, 1'b1, 1'b0);
    step("hold_1", 1'b0, 4'd8, 4'd8, 1'b1, 1'b0);
    mode = 2'b11;
    step("hold_11", 1'b0, 4'd8, 4'd8, 1'b1, 1'b0);
    set_din(1'b0);
    mode = 2'b01;
    step("resume_cnt2", 1'b0, 4'd8, 4'd8, 1'b1, 1'b0);
    step("resume_wrap", 1'b0, 4'd8, 4'd8, 1'b1, 1'b1);
    step("resume_cnt1", 1'b0, 4'd8, 4'd8, 1'b1, 1'b0);
    mask = 16'h0;
    step("empty_mask", 1'b0, 4'd0, 4'd8, 1'b0, 1'b0);
    mask = 16'hFFFF; dwell = 8'd200;
    for (int i = 0; i < 50; i++)
      step($sformatf("long_dwell_%0d", i), 1'b0, 4'd8, 4'd8, 1'b1, 1'b0);
    dwell = 8'd10;
    step("dwell_shrink", 1'b0, 4'd9, 4'd9, 1'b1, 1'b0);
    dwell = 8'd0;
    for (int c = 10; c < 16; c++)
      step($sformatf("dwell0_ch%0d", c), 1'b0, 4'(c), 4'(c), 1'b1, 1'b0);
    step("dwell0_wrap", 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    dwell = 8'd2;
    step("pre_reset_cnt1", 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    step("pre_reset_cnt2", 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 compare('{"async_reset", 1'b0, 10'h0});
    #1 rst_n = 1'b1;
    step("post_reset_0", 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    step("post_reset_1", 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    step("post_reset_adv", 1'b0, 4'd1, 4'd1, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
